// File: rtl/pulser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulser_pkg
//  Brief    : State encoding and width helper shared by pos_to_onehot_pulser.
//  Revision : 1.0  initial release
// ============================================================================
package pulser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits needed to index n values, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_dec
//  Brief    : Combinational bit-position to one-hot decoder with range flag.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_dec
  import pulser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POS_W = clog2_min1(WIDTH)
) (
  input  logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] onehot,
  output logic             in_range
);

  assign in_range = (32'(pos) < WIDTH);

  // Out-of-range positions match no line, so onehot is zero for them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign onehot[i] = (32'(pos) == i);
  end

endmodule
`default_nettype wire

// File: rtl/pos_to_onehot_pulser.sv
`default_nettype none
// ============================================================================
//  Module   : pos_to_onehot_pulser
//  Brief    : Accepts a bit position, drives its one-hot line for PULSE_LEN
//             cycles then idles GAP_LEN cycles. Define PULSER_HISTORY_EN to
//             add a sticky history of pulsed lines (hist / hist_clr).
//  Revision : 1.0  initial release
// ============================================================================
module pos_to_onehot_pulser
  import pulser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int POS_W     = clog2_min1(WIDTH),
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [POS_W-1:0] in_pos,
  output logic             in_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             err
`ifdef PULSER_HISTORY_EN
  ,
  input  logic             hist_clr,
  output logic [WIDTH-1:0] hist
`endif
);

  localparam int CNT_W = clog2_min1(((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_onehot;
  logic             w_in_range;

  onehot_dec #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_dec (
    .pos      (in_pos),
    .onehot   (w_onehot),
    .in_range (w_in_range)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      data      <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      data      <= w_data_nxt;
      out_valid <= w_valid_nxt;
      err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = data;
    w_valid_nxt = out_valid;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_in_range) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = PULSE_LOAD;
            w_data_nxt  = w_onehot;
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
            if (GAP_LEN > 0) begin
              w_state_nxt = GAP;
              w_cnt_nxt   = GAP_LOAD;
            end
          end
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          w_data_nxt  = '0;
          w_valid_nxt = 1'b0;
          if (GAP_LEN > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
  end

`ifdef PULSER_HISTORY_EN
  // Only the rising bit is recorded, so a clear during a held pulse sticks.
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] w_hist_set;

  assign w_hist_set = w_data_nxt & ~data;
  assign hist       = r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= (hist_clr ? '0 : r_hist) | w_hist_set;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pos_to_onehot_pulser.sv
`default_nettype none
// Bench for pos_to_onehot_pulser: scoreboarded random/directed traffic on the
// default build, plus small directed instances for range errors and GAP_LEN=0.
module tb_pos_to_onehot_pulser;

  localparam int P = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, err;
  logic [2:0] in_pos;
  logic [7:0] data;
`ifdef PULSER_HISTORY_EN
  logic       hist_clr;
  logic [7:0] hist;
  logic       b_hist_clr, c_hist_clr;
  logic [5:0] b_hist;
  logic [7:0] c_hist;
`endif

  logic       b_reset, b_in_valid, b_in_ready, b_out_valid, b_err;
  logic [2:0] b_in_pos;
  logic [5:0] b_data;
  logic       c_reset, c_in_valid, c_in_ready, c_out_valid, c_err;
  logic [2:0] c_in_pos;
  logic [7:0] c_data;

  always #5 clk = ~clk;

  pos_to_onehot_pulser #(.WIDTH(8), .PULSE_LEN(P), .GAP_LEN(G)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pos(in_pos),
    .in_ready(in_ready), .data(data), .out_valid(out_valid), .err(err)
`ifdef PULSER_HISTORY_EN
    , .hist_clr(hist_clr), .hist(hist)
`endif
  );

  pos_to_onehot_pulser #(.WIDTH(6), .PULSE_LEN(4), .GAP_LEN(1)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_pos(b_in_pos),
    .in_ready(b_in_ready), .data(b_data), .out_valid(b_out_valid), .err(b_err)
`ifdef PULSER_HISTORY_EN
    , .hist_clr(b_hist_clr), .hist(b_hist)
`endif
  );

  pos_to_onehot_pulser #(.WIDTH(8), .PULSE_LEN(1), .GAP_LEN(0)) dut_c (
    .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_pos(c_in_pos),
    .in_ready(c_in_ready), .data(c_data), .out_valid(c_out_valid), .err(c_err)
`ifdef PULSER_HISTORY_EN
    , .hist_clr(c_hist_clr), .hist(c_hist)
`endif
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         rises[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         free_at = 0;
  bit         exp_rdy = 1'b0;
  bit         chk_en = 1'b0;
  bit         acc = 1'b0;
  bit         prev_ov = 1'b0;
  logic [7:0] hist_m = '0;
  logic [7:0] hist_cur = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: an accepted position owns P output cycles, then the block is
  // busy until P+G+1 cycles after acceptance.
  task automatic tick(input bit v, input logic [2:0] p, input bit r, input bit clr);
    ev_t e;
    in_valid = v;
    in_pos   = p;
    reset    = r;
`ifdef PULSER_HISTORY_EN
    hist_clr = clr;
`endif
    exp_rdy = (cyc >= free_at);
    acc     = 1'b0;
    if (r) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      free_at = cyc + 1;
      hist_m  = '0;
    end else begin
      if (clr) hist_m = '0;
      if (v && exp_rdy) begin
        acc = 1'b1;
        for (int k = 1; k <= P; k++) begin
          e.cyc = cyc + k;
          e.d   = 8'(1 << p);
          exp_q.push_back(e);
        end
        hist_m  = hist_m | 8'(1 << p);
        free_at = cyc + P + G + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    hist_cur = hist_m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [2:0] p);
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(1'b1, p, 1'b0, 1'b0);
      n++;
    end
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("err_a", 64'(err), 64'd0);
      if (out_valid) begin
        if (!prev_ov) rises.push_back(cyc);
        check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("pulse_cycle", 64'(mon_e.cyc), 64'(cyc));
          check("data", 64'(data), 64'(mon_e.d));
        end
      end else begin
        check("data_idle", 64'(data), 64'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check("out_valid", 64'(out_valid), 64'd1);
          void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
`ifdef PULSER_HISTORY_EN
      check("hist", 64'(hist), 64'(hist_cur));
`endif
    end
  end

  initial begin
    int busy_n, ov_n;
    in_valid = 1'b0; in_pos = '0; reset = 1'b1;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_pos = '0;
    c_reset = 1'b1; c_in_valid = 1'b0; c_in_pos = '0;
`ifdef PULSER_HISTORY_EN
    hist_clr = 1'b0; b_hist_clr = 1'b0; c_hist_clr = 1'b0;
`endif
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    b_reset = 1'b0;
    c_reset = 1'b0;
    chk_en  = 1'b1;
    check("reset_ready", 64'(in_ready), 64'd1);
    check("reset_data", 64'(data), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);

    // Single pulse on line 3: four cycles high, five cycles busy.
    tick(1'b1, 3'd3, 1'b0, 1'b0);
    check("t1_data", 64'(data), 64'h08);
    busy_n = 0;
    ov_n   = 0;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) busy_n++;
      if (out_valid) ov_n++;
      tick(1'b0, 3'd0, 1'b0, 1'b0);
    end
    check("t1_busy_cycles", 64'(busy_n), 64'd5);
    check("t1_pulse_cycles", 64'(ov_n), 64'd4);

    // Held valid: second position waits out the first pulse and gap.
    idle(2);
    rises.delete();
    send(3'd0);
    send(3'd7);
    idle(8);
    check("t2_pulses", 64'(rises.size()), 64'd2);
    if (rises.size() == 2) check("t2_spacing", 64'(rises[1] - rises[0]), 64'd6);

    // Reset in the second drive cycle truncates the pulse.
    send(3'd5);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    check("t3_data", 64'(data), 64'd0);
    check("t3_out_valid", 64'(out_valid), 64'd0);
    check("t3_ready", 64'(in_ready), 64'd1);
    idle(6);

`ifdef PULSER_HISTORY_EN
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    send(3'd1);
    idle(6);
    send(3'd6);
    idle(6);
    check("t6_hist", 64'(hist), 64'h42);
    tick(1'b1, 3'd3, 1'b0, 1'b1);
    check("t6_accept", 64'(acc), 64'd1);
    check("t6_hist_clr", 64'(hist), 64'h08);
    idle(6);
`endif

    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
    end
    idle(10);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // Out-of-range position on a 6-line instance.
    b_in_valid = 1'b1;
    b_in_pos   = 3'd7;
    idle(1);
    b_in_valid = 1'b0;
    check("t4_err", 64'(b_err), 64'd1);
    check("t4_data", 64'(b_data), 64'd0);
    check("t4_out_valid", 64'(b_out_valid), 64'd0);
    check("t4_gap_ready", 64'(b_in_ready), 64'd0);
    idle(1);
    check("t4_err_clear", 64'(b_err), 64'd0);
    check("t4_ready", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1;
    b_in_pos   = 3'd5;
    idle(1);
    b_in_valid = 1'b0;
    check("t4_data_5", 64'(b_data), 64'h20);
    check("t4_no_err", 64'(b_err), 64'd0);

    // Single-cycle pulses with no gap, back to back.
    c_in_valid = 1'b1;
    c_in_pos   = 3'd2;
    idle(1);
    c_in_pos = 3'd5;
    check("t5_data_2", 64'(c_data), 64'h04);
    check("t5_busy", 64'(c_in_ready), 64'd0);
    idle(1);
    check("t5_data_gap", 64'(c_data), 64'h00);
    check("t5_ready", 64'(c_in_ready), 64'd1);
    idle(1);
    c_in_valid = 1'b0;
    check("t5_data_5", 64'(c_data), 64'h20);
    check("t5_out_valid", 64'(c_out_valid), 64'd1);
    idle(1);
    check("t5_data_end", 64'(c_data), 64'h00);

    idle(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
